// File: rtl/jtag_reg_bridge_if.sv
// Bus between the VJTAG adapter/host side and the register bridge back end.
// Strobe semantics: vs_cdr/vs_sdr/vs_udr/vs_uir are single-tck state flags sampled on posedge tck;
// a flag high at an edge performs its action exactly once for that edge, there is no ready/back-pressure.
interface jtag_reg_bridge_if #(
  parameter int ADDR_W = 3
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [7:0]            ir_in;
  logic                  tdi;
  logic                  vs_cdr;
  logic                  vs_sdr;
  logic                  vs_udr;
  logic                  vs_uir;
  logic [7:0]            status_in;
  logic                  tdo;
  logic [7:0]            ir_out;
  logic [8*NUM_REGS-1:0] regs_flat;
  logic                  wr_pulse;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;

  modport master (
    output ir_in, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, status_in,
    input  tdo, ir_out, regs_flat, wr_pulse, wr_addr, wr_data
  );

  modport slave (
    input  ir_in, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, status_in,
    output tdo, ir_out, regs_flat, wr_pulse, wr_addr, wr_data
  );
endinterface

// File: rtl/jtag_reg_bridge.sv
// Virtual-JTAG data-register back end: shifts the DR selected by ir_in and commits
// updates to a bank of 8-bit control registers, all in the tck domain.
module jtag_reg_bridge #(
  parameter int ADDR_W = 3
) (
  input  logic               tck,
  input  logic               reset_n,
  jtag_reg_bridge_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int SR_W     = (ADDR_W + 8 > 16) ? ADDR_W + 8 : 16;

  localparam logic [7:0] IR_WRITE_REG  = 8'h03;
  localparam logic [7:0] IR_READ_SEL   = 8'h04;
  localparam logic [7:0] IR_READ_DATA  = 8'h05;
  localparam logic [7:0] IR_GET_STATUS = 8'h06;
  localparam logic [7:0] IR_CLEAR      = 8'h07;

  logic [SR_W-1:0]   sr_q, sr_d, sr_shifted, sr_shr;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] upd_addr;
  logic [7:0]        upd_data;
  int                dr_len;

  assign upd_addr = sr_q[ADDR_W+7:8];
  assign upd_data = sr_q[7:0];
  assign sr_shr   = {1'b0, sr_q[SR_W-1:1]};

  always_comb begin
    dr_len = 1;
    case (bus.ir_in)
      IR_WRITE_REG:  dr_len = ADDR_W + 8;
      IR_READ_SEL:   dr_len = ADDR_W;
      IR_READ_DATA:  dr_len = 8;
      IR_GET_STATUS: dr_len = 16;
      default:       dr_len = 1;
    endcase
  end

  // tdi enters at bit L-1 of the active DR; bits above L-1 simply hold.
  always_comb begin
    sr_shifted = sr_q;
    for (int i = 0; i < SR_W; i++) begin
      if (i == dr_len - 1)     sr_shifted[i] = bus.tdi;
      else if (i < dr_len - 1) sr_shifted[i] = sr_shr[i];
    end
  end

  always_comb begin
    sr_d       = sr_q;
    regs_d     = regs_q;
    rd_ptr_d   = rd_ptr_q;
    wr_count_d = wr_count_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (bus.vs_cdr) begin
      case (bus.ir_in)
        IR_WRITE_REG:  sr_d = '0;
        IR_READ_DATA:  sr_d[7:0] = regs_q[rd_ptr_q];
        IR_GET_STATUS: sr_d[15:0] = {bus.status_in, wr_count_q};
        IR_READ_SEL, IR_CLEAR: ;
        default:       sr_d[0] = 1'b0;
      endcase
    end else if (bus.vs_sdr) begin
      sr_d = sr_shifted;
    end else if (bus.vs_udr) begin
      case (bus.ir_in)
        IR_WRITE_REG: begin
          regs_d[upd_addr] = upd_data;
          wr_addr_d        = upd_addr;
          wr_data_d        = upd_data;
          wr_pulse_d       = 1'b1;
          wr_count_d       = wr_count_q + 8'd1;
        end
        IR_READ_SEL:  rd_ptr_d = sr_q[ADDR_W-1:0];
        IR_READ_DATA: rd_ptr_d = rd_ptr_q + 1'b1;
        IR_CLEAR: begin
          for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
          rd_ptr_d   = '0;
          wr_count_d = '0;
        end
        default: ;
      endcase
    end else if (bus.vs_uir) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sr_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      sr_q       <= sr_d;
      regs_q     <= regs_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_count_q <= wr_count_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_flat[8*g +: 8] = regs_q[g];
  end

  assign bus.tdo      = sr_q[0];
  assign bus.ir_out   = 8'(rd_ptr_q);
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
endmodule
